l1_l2_arbiter: RTL

- Shares the single unified L2 port between the L1 I-cache (line refill reads) and the L1 D-cache (refill reads and dirty-line writebacks).
- Sits between the L1 I/D tops and the L2 top inside top.
- Registered request/response handshake toward each side; one L2 transaction in flight at a time.
- Default policy: round-robin, with an atomic writeback-then-refill pair for D.

---
 rtl/l1_l2_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/l1_l2_arbiter.sv
// ---------------------------------------------------------------------------
// l1_l2_arbiter
//
// Shares the single unified L2 port between the L1 I-cache (line refills)
// and the L1 D-cache (line refills and dirty-line writebacks). Exactly one
// L2 transaction is in flight at a time. All outputs are registered.
//
// Arbitration (default build): round-robin between I and D. A completed
// D writeback sets pair_lock, so the refill that normally follows a dirty
// miss is granted next, ahead of a waiting I request.
//
// Optional build macro ARB_FIXED_PRIO_EN: D has fixed priority over I.
// A 4-bit wait counter counts I's lost arbitrations. Once it reaches
// MAX_WAIT, I wins the next arbitration, even over pair_lock.
//
// Ports:
//   clk, nrst            rising-edge clock, async active-low reset
//   read_I_L2            I refill request (level), address_I_L2
//   ready_L2_I           one-cycle completion pulse to I, read_data_L2_I
//   read_D_L2/write_D_L2 D refill / writeback request (level),
//                        address_D_L2, write_data_D_L2
//   ready_L2_D           one-cycle completion pulse to D, read_data_L2_D
//   read_L1_L2/write_L1_L2, address_L1_L2, write_data_L1_L2
//                        request to L2, held until ready_L2_L1
//   ready_L2_L1          L2 completion pulse, read_data_L2_L1 valid with it
//   grant_D              1 while the current/last grant is D (debug)
// ---------------------------------------------------------------------------
module l1_l2_arbiter #(
  parameter int LINE_W   = 512,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_I_L2,
  input  logic [ADDR_W-1:0] address_I_L2,
  output logic              ready_L2_I,
  output logic [LINE_W-1:0] read_data_L2_I,
  input  logic              read_D_L2,
  input  logic              write_D_L2,
  input  logic [ADDR_W-1:0] address_D_L2,
  input  logic [LINE_W-1:0] write_data_D_L2,
  output logic              ready_L2_D,
  output logic [LINE_W-1:0] read_data_L2_D,
  output logic              read_L1_L2,
  output logic              write_L1_L2,
  output logic [ADDR_W-1:0] address_L1_L2,
  output logic [LINE_W-1:0] write_data_L1_L2,
  input  logic              ready_L2_L1,
  input  logic [LINE_W-1:0] read_data_L2_L1,
  output logic              grant_D
);

  // The wait counter is 4 bits wide, so MAX_WAIT must fit in 1..15.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("l1_l2_arbiter: MAX_WAIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Registered request toward L2
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } l2_req_t;

  state_t      state_q, state_d;
  l2_req_t     l2_q, l2_d;
  logic        gnt_d_q, gnt_d_d;       // winner of the current/last grant is D
  logic        ready_i_q, ready_i_d;
  logic        ready_d_q, ready_d_d;
  logic [LINE_W-1:0] rdata_i_q, rdata_i_d;
  logic [LINE_W-1:0] rdata_d_q, rdata_d_d;
  logic        pair_lock_q, pair_lock_d;

  logic        i_req;
  logic        d_req;
  logic        any_req;
  logic        win_d;                  // arbitration result, valid when any_req

  assign i_req   = read_I_L2;
  assign d_req   = read_D_L2 | write_D_L2;
  assign any_req = i_req | d_req;

`ifdef ARB_FIXED_PRIO_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       force_i;

  // I has waited long enough: it beats both D priority and pair_lock.
  assign force_i = i_req && (wait_cnt_q == 4'(MAX_WAIT));

  always_comb begin
    win_d = 1'b0;
    if (force_i)                 win_d = 1'b0;
    else if (pair_lock_q && d_req) win_d = 1'b1;
    else                         win_d = d_req;
  end
`else
  logic rr_d_next_q, rr_d_next_d;      // 1: D wins the next contested grant

  always_comb begin
    win_d = 1'b0;
    if (pair_lock_q && d_req)    win_d = 1'b1;
    else if (d_req && !i_req)    win_d = 1'b1;
    else if (i_req && !d_req)    win_d = 1'b0;
    else                         win_d = rr_d_next_q;
  end
`endif

  always_comb begin
    state_d     = state_q;
    l2_d        = l2_q;
    gnt_d_d     = gnt_d_q;
    ready_i_d   = 1'b0;
    ready_d_d   = 1'b0;
    rdata_i_d   = rdata_i_q;
    rdata_d_d   = rdata_d_q;
    pair_lock_d = pair_lock_q;
`ifdef ARB_FIXED_PRIO_EN
    wait_cnt_d  = wait_cnt_q;
`else
    rr_d_next_d = rr_d_next_q;
`endif

    case (state_q)
      S_IDLE: begin
        l2_d = '0;
        if (any_req) begin
          state_d     = S_REQ;
          gnt_d_d     = win_d;
          pair_lock_d = 1'b0;          // consumed by this arbitration
`ifdef ARB_FIXED_PRIO_EN
          if (!win_d)
            wait_cnt_d = '0;
          else if (i_req && wait_cnt_q != 4'hF)
            wait_cnt_d = wait_cnt_q + 4'd1;
`else
          rr_d_next_d = !win_d;
`endif
          if (win_d) begin
            // Writeback first when D asks for both; the refill follows
            // under pair_lock.
            l2_d.wr    = write_D_L2;
            l2_d.rd    = !write_D_L2;
            l2_d.addr  = address_D_L2;
            l2_d.wdata = write_data_D_L2;
          end else begin
            l2_d.rd    = 1'b1;
            l2_d.addr  = address_I_L2;
          end
        end
      end

      S_REQ: begin
        if (ready_L2_L1) begin
          state_d = S_RESP;
          l2_d    = '0;
          if (gnt_d_q) ready_d_d = 1'b1;
          else         ready_i_d = 1'b1;
          // Only reads return a line; a write completion leaves the
          // requester's read data untouched.
          if (l2_q.rd) begin
            if (gnt_d_q) rdata_d_d = read_data_L2_L1;
            else         rdata_i_d = read_data_L2_L1;
          end
          if (gnt_d_q && l2_q.wr) pair_lock_d = 1'b1;
        end
      end

      S_RESP: begin
        // ready pulse is live during this state; drop it on exit
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      l2_q        <= '0;
      gnt_d_q     <= 1'b0;
      ready_i_q   <= 1'b0;
      ready_d_q   <= 1'b0;
      rdata_i_q   <= '0;
      rdata_d_q   <= '0;
      pair_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l2_q        <= l2_d;
      gnt_d_q     <= gnt_d_d;
      ready_i_q   <= ready_i_d;
      ready_d_q   <= ready_d_d;
      rdata_i_q   <= rdata_i_d;
      rdata_d_q   <= rdata_d_d;
      pair_lock_q <= pair_lock_d;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rr_d_next_q <= 1'b0;    // I goes first after reset
    else       rr_d_next_q <= rr_d_next_d;
  end
`endif

  assign read_L1_L2       = l2_q.rd;
  assign write_L1_L2      = l2_q.wr;
  assign address_L1_L2    = l2_q.addr;
  assign write_data_L1_L2 = l2_q.wdata;
  assign ready_L2_I       = ready_i_q;
  assign ready_L2_D       = ready_d_q;
  assign read_data_L2_I   = rdata_i_q;
  assign read_data_L2_D   = rdata_d_q;
  assign grant_D          = gnt_d_q;

endmodule
